// File: rtl/param_sync_counter.sv
// Parameterised modulo counter with prescaler tick, up/down/ping-pong modes and synchronous load.
// Optional build macro PARAM_SYNC_COUNTER_SAT_EN: saturate at the end values instead of wrapping (pingpong=0).
module param_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int DIV     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             pingpong,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             going_down
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PMAX  = PW'(DIV - 1);
  localparam logic [PW-1:0]  PONE  = PW'(1);
  // Count arithmetic carries one extra bit so MODULUS = 2^WIDTH is representable.
  localparam logic [WIDTH:0] MAXV  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] MAXM1 = (WIDTH+1)'(MODULUS - 2);
  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);

  logic [PW-1:0]    pre, pre_n;
  logic [WIDTH:0]   cur, lv_ext, ld_v;
  logic [WIDTH-1:0] out_n;
  logic             tc_n, gd_n, tick;

  assign cur    = {1'b0, out};
  assign lv_ext = {1'b0, load_val};
  assign ld_v   = (lv_ext > MAXV) ? MAXV : lv_ext;
  assign tick   = en & (pre == PMAX);

  always_comb begin
    out_n = out;
    tc_n  = 1'b0;
    gd_n  = going_down;
    pre_n = pre;
    if (load) begin
      out_n = WIDTH'(ld_v);
      pre_n = '0;
      if (pingpong) begin
        if (ld_v == MAXV)     gd_n = 1'b1;
        else if (ld_v == '0)  gd_n = 1'b0;
      end
    end else begin
      if (en) pre_n = (pre == PMAX) ? '0 : pre + PONE;
      if (tick) begin
        if (pingpong) begin
          if (!going_down) begin
            if (cur == MAXV) begin
              // entered at the top while heading up: bounce back off it
              out_n = WIDTH'(cur - ONE);
              gd_n  = 1'b1;
              tc_n  = 1'b1;
            end else if (cur == MAXM1) begin
              out_n = WIDTH'(MAXV);
              gd_n  = 1'b1;
              tc_n  = 1'b1;
            end else begin
              out_n = WIDTH'(cur + ONE);
            end
          end else begin
            if (cur == '0) begin
              out_n = WIDTH'(ONE);
              gd_n  = 1'b0;
              tc_n  = 1'b1;
            end else if (cur == ONE) begin
              out_n = '0;
              gd_n  = 1'b0;
              tc_n  = 1'b1;
            end else begin
              out_n = WIDTH'(cur - ONE);
            end
          end
        end else begin
          gd_n = dir;
          if (!dir) begin
            if (cur == MAXV) begin
`ifdef PARAM_SYNC_COUNTER_SAT_EN
              out_n = out;
`else
              out_n = '0;
              tc_n  = 1'b1;
`endif
            end else begin
              out_n = WIDTH'(cur + ONE);
`ifdef PARAM_SYNC_COUNTER_SAT_EN
              tc_n  = (cur == MAXM1);
`endif
            end
          end else begin
            if (cur == '0) begin
`ifdef PARAM_SYNC_COUNTER_SAT_EN
              out_n = out;
`else
              out_n = WIDTH'(MAXV);
              tc_n  = 1'b1;
`endif
            end else begin
              out_n = WIDTH'(cur - ONE);
`ifdef PARAM_SYNC_COUNTER_SAT_EN
              tc_n  = (cur == ONE);
`endif
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out        <= '0;
      pre        <= '0;
      tc         <= 1'b0;
      going_down <= 1'b0;
    end else begin
      out        <= out_n;
      pre        <= pre_n;
      tc         <= tc_n;
      going_down <= gd_n;
    end
  end

endmodule

// File: tb/tb_param_sync_counter.sv
// Directed bench for param_sync_counter: four parameterisations share one stimulus bus.
module tb_param_sync_counter;

  logic       clk = 1'b0;
  logic       rst, en, load, dir, pp;
  logic [3:0] lv;
  logic [3:0] oA, oB, oD;
  logic [2:0] oC;
  logic       tcA, tcB, tcC, tcD, gdA, gdB, gdC, gdD;
  int         nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  param_sync_counter #(.WIDTH(4), .MODULUS(16), .DIV(1)) dA (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv), .dir(dir),
    .pingpong(pp), .out(oA), .tc(tcA), .going_down(gdA));
  param_sync_counter #(.WIDTH(4), .MODULUS(10), .DIV(4)) dB (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv), .dir(dir),
    .pingpong(pp), .out(oB), .tc(tcB), .going_down(gdB));
  param_sync_counter #(.WIDTH(3), .MODULUS(6), .DIV(1)) dC (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv[2:0]), .dir(dir),
    .pingpong(pp), .out(oC), .tc(tcC), .going_down(gdC));
  param_sync_counter #(.WIDTH(4), .MODULUS(8), .DIV(1)) dD (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv), .dir(dir),
    .pingpong(pp), .out(oD), .tc(tcD), .going_down(gdD));

  typedef struct {
    logic en, load, dir, pp;
    logic [3:0] lv;
    int eo;
    logic etc, egd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic l, logic d, logic p, int v, int o, logic t, logic g);
    vec_t r;
    r.en = e; r.load = l; r.dir = d; r.pp = p; r.lv = 4'(v);
    r.eo = o; r.etc = t; r.egd = g;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after an edge, so the pulse never straddles a clock edge.
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; dir = 1'b0; pp = 1'b0; lv = '0;

    // reset held across an enabled edge
    step();
    chk("rst_out", oA, 0); chk("rst_tc", tcA, 0); chk("rst_gd", gdA, 0);
    chk("rst_outB", oB, 0);
    rst = 1'b0;

    // up count, DIV=1, MODULUS=16
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("up16_out[%0d]", i), oA, i % 16);
      chk($sformatf("up16_tc[%0d]", i), tcA, (i == 16) ? 1 : 0);
    end

    // down count with prescaler DIV=4, MODULUS=10
    pulse_rst();
    dir = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(); chk($sformatf("div_hold[%0d]", i), oB, 0);
    end
    step(); chk("div_wrap_out", oB, 9); chk("div_wrap_tc", tcB, 1); chk("div_gd", gdB, 1);
    step(); chk("div_tc_clear", tcB, 0);
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("en_freeze[%0d]", i), oB, 9);
    end
    en = 1'b1;
    step(); chk("en_resume_out", oB, 8); chk("en_resume_tc", tcB, 0);

    // ping-pong / mode-switch / load table on MODULUS=6 instance
    tbl.push_back(mk(1,0,0,1,0, 1,0,0));
    tbl.push_back(mk(1,0,0,1,0, 2,0,0));
    tbl.push_back(mk(1,0,0,1,0, 3,0,0));
    tbl.push_back(mk(1,0,0,1,0, 4,0,0));
    tbl.push_back(mk(1,0,0,1,0, 5,1,1));
    tbl.push_back(mk(1,0,0,1,0, 4,0,1));
    tbl.push_back(mk(1,0,0,1,0, 3,0,1));
    tbl.push_back(mk(1,0,0,1,0, 2,0,1));
    tbl.push_back(mk(1,0,0,1,0, 1,0,1));
    tbl.push_back(mk(1,0,0,1,0, 0,1,0));
    tbl.push_back(mk(1,0,0,1,0, 1,0,0));
    tbl.push_back(mk(1,0,0,1,0, 2,0,0));
    tbl.push_back(mk(1,1,0,1,5, 5,0,1));
    tbl.push_back(mk(1,0,0,1,0, 4,0,1));
    tbl.push_back(mk(1,0,0,0,0, 5,0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,1,0));
    tbl.push_back(mk(1,0,1,0,0, 5,1,1));
    tbl.push_back(mk(1,0,0,0,0, 0,1,0));
    tbl.push_back(mk(1,1,0,0,5, 5,0,0));
    tbl.push_back(mk(1,0,0,1,0, 4,1,1));
    tbl.push_back(mk(1,0,0,1,0, 3,0,1));
    tbl.push_back(mk(1,1,1,0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,1,0, 1,1,0));
    tbl.push_back(mk(0,0,0,1,0, 1,0,0));
    tbl.push_back(mk(0,1,0,1,3, 3,0,0));
    tbl.push_back(mk(0,1,0,1,7, 5,0,1));
    tbl.push_back(mk(0,1,0,1,0, 0,0,0));
    pulse_rst();
    foreach (tbl[i]) begin
      en = tbl[i].en; load = tbl[i].load; dir = tbl[i].dir; pp = tbl[i].pp; lv = tbl[i].lv;
      step();
      chk($sformatf("vec_out[%0d]", i), oC, tbl[i].eo);
      chk($sformatf("vec_tc[%0d]", i), tcC, tbl[i].etc);
      chk($sformatf("vec_gd[%0d]", i), gdC, tbl[i].egd);
    end
    load = 1'b0; pp = 1'b0; dir = 1'b0; en = 1'b1;

    // load clamps and wins over a coincident tick; prescaler restarts
    pulse_rst();
    step(); step(); step();
    load = 1'b1; lv = 4'd13;
    step(); chk("ld_clamp_out", oB, 9); chk("ld_clamp_tc", tcB, 0);
    load = 1'b0;
    step(); step(); step();
    chk("ld_pre_clear", oB, 9);
    step(); chk("ld_after_out", oB, 0); chk("ld_after_tc", tcB, 1);

    // asynchronous reset between edges
    pulse_rst();
    for (int i = 0; i < 7; i++) step();
    chk("mid_out", oA, 7);
    rst = 1'b1;
    #1;
    chk("async_out", oA, 0); chk("async_tc", tcA, 0);
    step(); chk("async_hold", oA, 0);
    rst = 1'b0;
    step(); chk("async_restart", oA, 1);

    // MODULUS=8 end behaviour: wrap by default, saturate with the macro
    pulse_rst();
    for (int i = 0; i < 6; i++) step();
    step(); chk("m8_top", oD, 7);
`ifdef PARAM_SYNC_COUNTER_SAT_EN
    chk("m8_top_tc", tcD, 1);
    step(); chk("sat_hold", oD, 7); chk("sat_hold_tc", tcD, 0);
    step(); chk("sat_hold2", oD, 7); chk("sat_hold2_tc", tcD, 0);
`else
    chk("m8_top_tc", tcD, 0);
    step(); chk("wrap_out", oD, 0); chk("wrap_tc", tcD, 1);
    step(); chk("wrap_next", oD, 1); chk("wrap_next_tc", tcD, 0);
`endif
    load = 1'b1; lv = 4'd2;
    step(); chk("m8_load", oD, 2);
    load = 1'b0;
    step(); chk("m8_resume3", oD, 3);
    step(); chk("m8_resume4", oD, 4);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
